// File: rtl/gpc_mem_responder.sv
// gpc_mem_responder: DEPTH x DW word memory with registered reads, one write per mode pulse
// and a sequential clear on erase. Optional build macro: GPC_MEM_PARITY_EN (per-word parity).
module gpc_mem_responder #(
   parameter int DEPTH  = 64,
   parameter int AW     = 6,
   parameter int DW     = 8,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          erase,
   input  logic [AW-1:0] adrs,
   input  logic          mode,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] out,
`ifdef GPC_MEM_PARITY_EN
   output logic          parity_err,
`endif
   output logic          ready
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t        state;
   logic [AW-1:0] clr_ptr;
   logic          swept;
   logic          mode_d;
   logic          clr_wrap;

   logic          wr_en;
   logic [AW-1:0] wr_adr;
   logic [DW-1:0] wr_dat;

   logic [DW-1:0] mem [DEPTH];
`ifdef GPC_MEM_PARITY_EN
   logic [DEPTH-1:0] par_bits;
`endif

   assign clr_wrap = (clr_ptr == AW'(DEPTH - 1));

   // Single write port: the clear sweep owns it in CLEAR, a mode rising edge owns it in IDLE.
   always_comb begin
      wr_en  = 1'b0;
      wr_adr = adrs;
      wr_dat = data;
      if (state == CLEAR) begin
         wr_en  = 1'b1;
         wr_adr = clr_ptr;
         wr_dat = '0;
      end else if (!erase && mode && !mode_d) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_adr] <= wr_dat;
      end
   end

`ifdef GPC_MEM_PARITY_EN
   always_ff @(posedge clk) begin
      if (wr_en) begin
         par_bits[wr_adr] <= ^wr_dat;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (erase) begin
         state  <= CLEAR;
         ready  <= 1'b0;
         mode_d <= 1'b0;
         if (state == IDLE) begin
            clr_ptr <= '0;
            swept   <= 1'b0;
         end else begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_wrap) begin
               swept <= 1'b1;
            end
         end
      end else begin
         mode_d <= mode;
         if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_wrap) begin
               swept <= 1'b1;
            end
            // The edge that clears the last word may already hand over to IDLE.
            if (swept || clr_wrap) begin
               state <= IDLE;
               ready <= 1'b1;
            end
         end
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         // In IDLE the write address is adrs, so a same-edge write is forwarded directly.
         always_ff @(posedge clk) begin
            if (erase || state == CLEAR) begin
               out <= '0;
`ifdef GPC_MEM_PARITY_EN
               parity_err <= 1'b0;
`endif
            end else begin
               out <= wr_en ? data : mem[adrs];
`ifdef GPC_MEM_PARITY_EN
               parity_err <= wr_en ? 1'b0 : ((^mem[adrs]) ^ par_bits[adrs]);
`endif
            end
         end
      end else begin : g_lat2
         logic [AW-1:0] adr_q;
         always_ff @(posedge clk) begin
            if (erase) begin
               adr_q <= '0;
               out   <= '0;
`ifdef GPC_MEM_PARITY_EN
               parity_err <= 1'b0;
`endif
            end else begin
               adr_q <= adrs;
               out   <= (state == IDLE) ? mem[adr_q] : '0;
`ifdef GPC_MEM_PARITY_EN
               parity_err <= (state == IDLE) ? ((^mem[adr_q]) ^ par_bits[adr_q]) : 1'b0;
`endif
            end
         end
      end
   endgenerate

endmodule
